blake2_block_sequencer: RTL and testbench
=========================================

BLAKE2_BLOCK_SEQUENCER -- requirements
Module: blake2_block_sequencer

Interface
REQ-001 SHALL have parameter proc_bus_width, default 32, processor word width in bits; legal values 8, 16, 32, 64, 128.
REQ-002 SHALL derive WPB = 1024/proc_bus_width (words per block) and BPW = proc_bus_width/8 (bytes per word).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 new_hash_request  input  1  start a new message.
REQ-006 data_in  input  proc_bus_width  message word.
REQ-007 valid_in  input  1  data_in valid.
REQ-008 last_in  input  1  qualifies data_in as the final word of the message.
REQ-009 last_bytes  input  clog2(BPW)+1  valid bytes in the last word, 0..BPW, MSB-first; ignored unless last_in=1.
REQ-010 stop_sending  output  1  backpressure; a word is accepted only when valid_in=1 and stop_sending=0.
REQ-011 init, next  output  1 each  one-cycle command pulses to the hash core.
REQ-012 final_block  output  1  final-block flag to the core, valid with next.
REQ-013 block  output  1024  assembled block; data_length  output  128  message byte count.
REQ-014 hash_ready  input  1; digest  input  512; digest_valid  input  1  core status and result.
REQ-015 digest_out  output  512; digest_out_valid  output  1  captured result, single-cycle pulse.

Function
REQ-016 SHALL implement states IDLE, INIT, WAIT_CORE_INIT, FILL, ISSUE, WAIT_CORE_BLOCK, WAIT_DIGEST.
REQ-017 IDLE: on new_hash_request=1, clear block, word index and byte counter, then go to INIT; otherwise stay in IDLE.
REQ-018 INIT: assert init for exactly one cycle, then go to WAIT_CORE_INIT.
REQ-019 WAIT_CORE_* states: ignore hash_ready in the first cycle after entry, then leave on hash_ready=1.
REQ-020 WAIT_CORE_INIT exits to FILL; WAIT_CORE_BLOCK exits to FILL if the block was non-final, else to WAIT_DIGEST.
REQ-021 stop_sending SHALL be 0 only in FILL, and 1 in every other state and during reset.
REQ-022 Word k of a block (k = 0..WPB-1) SHALL be written to block[1023-k*proc_bus_width -: proc_bus_width], so the first word lands in the MSBs.
REQ-023 Each accepted non-last word SHALL add BPW to the byte counter.
REQ-024 The last word SHALL add last_bytes to the byte counter; its bytes beyond last_bytes and all unfilled words SHALL be zero.
REQ-025 A block is complete when word WPB-1 is accepted or a last word is accepted; on completion go to ISSUE.
REQ-026 ISSUE: pulse next for one cycle, with final_block=1 iff the block ended with last_in, and with block and data_length stable.
REQ-027 block and data_length SHALL stay stable from the ISSUE cycle until leaving WAIT_CORE_BLOCK.
REQ-028 After a non-final block, the block register SHALL be cleared and the word index set to 0 before the next word is accepted.
REQ-029 A last word that fills the block SHALL produce exactly one next pulse, with final_block=1.
REQ-030 last_in=1 with last_bytes=0 as the first word SHALL produce an all-zero final block with data_length=0 (empty message).
REQ-031 data_length SHALL wrap modulo 2^128; no saturation.
REQ-032 WAIT_DIGEST: on digest_valid=1, register digest into digest_out and pulse digest_out_valid the next cycle, then go to IDLE.
REQ-033 digest_out SHALL hold its value until the next capture.
REQ-034 new_hash_request outside IDLE SHALL be ignored; a simultaneous valid_in in IDLE is not accepted.

Reset
REQ-035 reset SHALL force IDLE from any state, including mid-message, discarding partial data.
REQ-036 reset SHALL clear all outputs: stop_sending=1, init=next=final_block=digest_out_valid=0, block=0, data_length=0, digest_out=0.

Structure
REQ-037 State encodings, block width (1024), length width (128) and digest width (512) SHALL live in shared package blake2_ctrl_pkg.
REQ-038 SHALL contain one sub-module, blake2_word_packer, holding word index, block register and byte counter; the FSM stays in the top.

Verification
REQ-039 proc_bus_width=32, 3-byte message 0x616263xx, last_bytes=3 -> one next with final_block=1, block[1023:1000]=0x616263, all other bits 0, data_length=3.
REQ-040 32 words with last on word 32 (128 bytes) -> exactly one next, final_block=1, data_length=128.
REQ-041 33 words, last_bytes=4 -> first next has final_block=0 and data_length=128; second has final_block=1, data_length=132, and only block[1023:992] nonzero.
REQ-042 new_hash_request followed by last_in with last_bytes=0 -> final block all zero, data_length=0, digest_out_valid pulses once.
REQ-043 hash_ready held low 20 cycles after next -> stop_sending stays 1 and no words are accepted; resumes on hash_ready=1.
REQ-044 reset asserted mid-FILL after 5 words -> IDLE next cycle, outputs at reset values, and a new message hashes correctly.

Source files
------------

// File: rtl/blake2_ctrl_pkg.sv
// Shared definitions for the BLAKE2 block sequencer.
//   - block, length and digest widths of the hash core interface
//   - sequencer FSM state encoding
package blake2_ctrl_pkg;

    localparam int BLOCK_W  = 1024;
    localparam int LEN_W    = 128;
    localparam int DIGEST_W = 512;

    typedef enum logic [2:0] {
        ST_IDLE            = 3'd0,
        ST_INIT            = 3'd1,
        ST_WAIT_CORE_INIT  = 3'd2,
        ST_FILL            = 3'd3,
        ST_ISSUE           = 3'd4,
        ST_WAIT_CORE_BLOCK = 3'd5,
        ST_WAIT_DIGEST     = 3'd6
    } state_t;

endpackage

// File: rtl/blake2_word_packer.sv
// Packs processor words into a 1024-bit block, MSB-first, and keeps the
// running message byte count.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   clear             start of message: zero block, word index and byte count
//   clear_block       start of a follow-on block: zero block and word index
//   accept            data_in is taken this cycle
//   data_in, last_in, last_bytes   word, final-word flag, valid bytes in final word
//   block_done        accepted word completes the block (combinational)
//   block, data_length             registered block and byte count
module blake2_word_packer
    import blake2_ctrl_pkg::*;
#(
    parameter int proc_bus_width = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   clear,
    input  logic                                   clear_block,
    input  logic                                   accept,
    input  logic [proc_bus_width-1:0]              data_in,
    input  logic                                   last_in,
    input  logic [$clog2(proc_bus_width/8):0]      last_bytes,
    output logic                                   block_done,
    output logic [BLOCK_W-1:0]                     block,
    output logic [LEN_W-1:0]                       data_length
);

    localparam int WPB   = BLOCK_W / proc_bus_width;
    localparam int BPW   = proc_bus_width / 8;
    localparam int LB_W  = $clog2(BPW) + 1;
    localparam int IDX_W = $clog2(WPB);

    logic [IDX_W-1:0]          idx_r;
    logic [proc_bus_width-1:0] keep_mask_s;
    logic [proc_bus_width-1:0] word_s;
    logic [LEN_W-1:0]          inc_s;
    logic [31:0]               shift_s;

    // Mask off trailing bytes of a final word and choose the byte increment.
    always_comb begin
        shift_s     = {{(32-LB_W){1'b0}}, last_bytes} << 3;
        // Valid bytes are the most significant ones; a shift of the full
        // width leaves the whole word kept.
        keep_mask_s = ~({proc_bus_width{1'b1}} >> shift_s);
        if (last_in) begin
            word_s = data_in & keep_mask_s;
            inc_s  = LEN_W'(last_bytes);
        end else begin
            word_s = data_in;
            inc_s  = LEN_W'(BPW);
        end
        block_done = accept && (last_in || (idx_r == IDX_W'(WPB - 1)));
    end

    // Word index, block register and byte counter.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx_r       <= '0;
            block       <= '0;
            data_length <= '0;
        end else if (clear_block) begin
            idx_r <= '0;
            block <= '0;
        end else if (accept) begin
            block[BLOCK_W-1 - int'(idx_r)*proc_bus_width -: proc_bus_width] <= word_s;
            idx_r       <= idx_r + IDX_W'(1);
            data_length <= data_length + inc_s;   // wraps modulo 2^128
        end
    end

endmodule

// File: rtl/blake2_block_sequencer.sv
// Feeds a message, word by word, into a BLAKE2 core as 1024-bit blocks and
// captures the resulting digest.
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   new_hash_request              start a new message (honoured in IDLE only)
//   data_in, valid_in, last_in, last_bytes   message word stream
//   stop_sending                  backpressure, low only while filling a block
//   init, next, final_block       command pulses to the core
//   block, data_length            block and byte count presented to the core
//   hash_ready, digest, digest_valid         core status and result
//   digest_out, digest_out_valid  captured digest and one-cycle strobe
module blake2_block_sequencer
    import blake2_ctrl_pkg::*;
#(
    parameter int proc_bus_width = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              new_hash_request,
    input  logic [proc_bus_width-1:0]         data_in,
    input  logic                              valid_in,
    input  logic                              last_in,
    input  logic [$clog2(proc_bus_width/8):0] last_bytes,
    output logic                              stop_sending,
    output logic                              init,
    output logic                              next,
    output logic                              final_block,
    output logic [BLOCK_W-1:0]                block,
    output logic [LEN_W-1:0]                  data_length,
    input  logic                              hash_ready,
    input  logic [DIGEST_W-1:0]               digest,
    input  logic                              digest_valid,
    output logic [DIGEST_W-1:0]               digest_out,
    output logic                              digest_out_valid
);

    state_t state_r;
    state_t state_next_s;
    logic   wait_armed_r;
    logic   last_block_r;
    logic   accept_s;
    logic   clear_s;
    logic   clear_block_s;
    logic   block_done_s;

    assign accept_s = valid_in && (state_r == ST_FILL);

    blake2_word_packer #(
        .proc_bus_width (proc_bus_width)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear_s),
        .clear_block (clear_block_s),
        .accept      (accept_s),
        .data_in     (data_in),
        .last_in     (last_in),
        .last_bytes  (last_bytes),
        .block_done  (block_done_s),
        .block       (block),
        .data_length (data_length)
    );

    // Next-state logic and packer control strobes.
    always_comb begin
        state_next_s  = state_r;
        clear_s       = 1'b0;
        clear_block_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (new_hash_request) begin
                    clear_s      = 1'b1;
                    state_next_s = ST_INIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                state_next_s = ST_WAIT_CORE_INIT;
            end
            ST_WAIT_CORE_INIT: begin
                if (wait_armed_r && hash_ready) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_WAIT_CORE_INIT;
                end
            end
            ST_FILL: begin
                if (block_done_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_WAIT_CORE_BLOCK;
            end
            ST_WAIT_CORE_BLOCK: begin
                if (wait_armed_r && hash_ready) begin
                    if (last_block_r) begin
                        state_next_s = ST_WAIT_DIGEST;
                    end else begin
                        // Block is only released now, so it stays stable
                        // for the whole time the core is absorbing it.
                        clear_block_s = 1'b1;
                        state_next_s  = ST_FILL;
                    end
                end else begin
                    state_next_s = ST_WAIT_CORE_BLOCK;
                end
            end
            ST_WAIT_DIGEST: begin
                if (digest_valid) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_DIGEST;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered outputs decoded from the next state,
    // so every output lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            wait_armed_r     <= 1'b0;
            last_block_r     <= 1'b0;
            stop_sending     <= 1'b1;
            init             <= 1'b0;
            next             <= 1'b0;
            final_block      <= 1'b0;
            digest_out       <= '0;
            digest_out_valid <= 1'b0;
        end else begin
            state_r <= state_next_s;
            // Armed from the second cycle spent in a state onwards; the
            // first cycle of a wait state ignores hash_ready.
            wait_armed_r <= (state_next_s == state_r);
            if (clear_s) begin
                last_block_r <= 1'b0;
            end else if (block_done_s) begin
                last_block_r <= last_in;
            end
            stop_sending <= (state_next_s != ST_FILL);
            init         <= (state_next_s == ST_INIT);
            next         <= (state_next_s == ST_ISSUE);
            // ISSUE is only reachable from a completing word in FILL.
            final_block  <= (state_next_s == ST_ISSUE) && last_in;
            if ((state_r == ST_WAIT_DIGEST) && digest_valid) begin
                digest_out       <= digest;
                digest_out_valid <= 1'b1;
            end else begin
                digest_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blake2_block_sequencer.sv
// Scoreboard bench for blake2_block_sequencer (proc_bus_width = 32).
// Stimulus pushes the expected blocks; a monitor compares on every next
// pulse and every digest_out_valid pulse.
module tb_blake2_block_sequencer;

    logic          clk = 1'b0;
    logic          reset;
    logic          new_hash_request;
    logic [31:0]   data_in;
    logic          valid_in;
    logic          last_in;
    logic [2:0]    last_bytes;
    logic          stop_sending;
    logic          init;
    logic          next;
    logic          final_block;
    logic [1023:0] block;
    logic [127:0]  data_length;
    logic          hash_ready;
    logic [511:0]  digest;
    logic          digest_valid;
    logic [511:0]  digest_out;
    logic          digest_out_valid;

    typedef struct {
        logic          fin;
        logic [127:0]  len;
        logic [1023:0] blk;
    } exp_t;

    exp_t         eq[$];
    logic [511:0] dq[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           dig_issued = 0;
    int           dig_seen   = 0;
    logic [511:0] last_digest = '0;
    logic         stall_en = 1'b0;

    blake2_block_sequencer #(.proc_bus_width(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .new_hash_request (new_hash_request),
        .data_in          (data_in),
        .valid_in         (valid_in),
        .last_in          (last_in),
        .last_bytes       (last_bytes),
        .stop_sending     (stop_sending),
        .init             (init),
        .next             (next),
        .final_block      (final_block),
        .block            (block),
        .data_length      (data_length),
        .hash_ready       (hash_ready),
        .digest           (digest),
        .digest_valid     (digest_valid),
        .digest_out       (digest_out),
        .digest_out_valid (digest_out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hand-written byte keep table for the last word (valid bytes are MSB-first).
    function automatic logic [31:0] keep_bytes(input logic [31:0] w, input int lb);
        case (lb)
            0: keep_bytes = 32'h0000_0000;
            1: keep_bytes = w & 32'hFF00_0000;
            2: keep_bytes = w & 32'hFFFF_0000;
            3: keep_bytes = w & 32'hFFFF_FF00;
            default: keep_bytes = w;
        endcase
    endfunction

    function automatic logic [31:0] msg_word(input int id, input int i);
        msg_word = {8'(id), 8'(i), 8'hA5, 8'(i) ^ 8'h3C};
    endfunction

    task automatic send_word(input logic [31:0] w, input logic last, input int lb);
        int budget = 200;
        valid_in   = 1'b1;
        data_in    = w;
        last_in    = last;
        last_bytes = 3'(lb);
        while (stop_sending && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_checks++;
        if (budget == 0) begin
            n_fail++;
            $display("FAIL send_timeout: word %h never accepted", w);
        end
        @(negedge clk);
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic wait_digest(input int target);
        int budget = 400;
        while (dig_seen < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("digest_arrival", 128'(dig_seen), 128'(target));
    endtask

    // Whole message: expected blocks pushed first, then words streamed.
    task automatic run_msg(input int id, input int n, input int lb, input logic [31:0] w0);
        exp_t          e;
        logic [1023:0] blk = '0;
        logic [127:0]  len = '0;
        logic [31:0]   w;
        int            target;
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? w0 : msg_word(id, i);
            if (i == n - 1) begin
                blk[1023 - 32*(i % 32) -: 32] = keep_bytes(w, lb);
                len = len + 128'(lb);
            end else begin
                blk[1023 - 32*(i % 32) -: 32] = w;
                len = len + 128'd4;
            end
            if ((i % 32) == 31 || i == n - 1) begin
                e.fin = (i == n - 1);
                e.len = len;
                e.blk = blk;
                eq.push_back(e);
                blk = '0;
            end
        end
        target = dig_seen + 1;
        // Request with a word already valid: that word must not be taken in IDLE.
        new_hash_request = 1'b1;
        valid_in   = 1'b1;
        data_in    = w0;
        last_in    = (n == 1);
        last_bytes = 3'(lb);
        @(negedge clk);
        new_hash_request = 1'b0;
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? w0 : msg_word(id, i);
            send_word(w, (i == n - 1), (i == n - 1) ? lb : 4);
        end
        wait_digest(target);
        repeat (3) @(negedge clk);
    endtask

    // Block monitor: compares every next pulse against the scoreboard.
    initial begin
        exp_t e;
        logic prev_next = 1'b0;
        logic prev_init = 1'b0;
        forever begin
            @(negedge clk);
            if (init) begin
                chk("init_single_pulse", 128'(prev_init), 128'd0);
            end
            if (next) begin
                chk("next_single_pulse", 128'(prev_next), 128'd0);
                n_checks++;
                if (eq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_next: got next with len %0d, expected none", data_length);
                end else begin
                    e = eq.pop_front();
                    chk("final_block", 128'(final_block), 128'(e.fin));
                    chk("data_length", data_length, e.len);
                    n_checks++;
                    if (block !== e.blk) begin
                        n_fail++;
                        for (int k = 0; k < 32; k++) begin
                            if (block[1023 - 32*k -: 32] !== e.blk[1023 - 32*k -: 32]) begin
                                $display("FAIL block word %0d: got %h expected %h",
                                         k, block[1023 - 32*k -: 32], e.blk[1023 - 32*k -: 32]);
                                break;
                            end
                        end
                    end
                end
            end
            prev_next = next;
            prev_init = init;
        end
    end

    // Digest monitor.
    initial begin
        logic [511:0] d;
        logic prev_dov = 1'b0;
        forever begin
            @(negedge clk);
            if (digest_out_valid) begin
                chk("digest_out_valid_pulse", 128'(prev_dov), 128'd0);
                n_checks++;
                if (dq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_digest: got %h expected none", digest_out[127:0]);
                end else begin
                    d = dq.pop_front();
                    if (digest_out !== d) begin
                        n_fail++;
                        $display("FAIL digest_out: got %h expected %h", digest_out[127:0], d[127:0]);
                    end
                end
                dig_seen++;
            end
            prev_dov = digest_out_valid;
        end
    end

    // Core model: optional stall after a non-final block, digest after a final one.
    initial begin
        logic [511:0] d;
        forever begin
            @(negedge clk);
            if (next && !final_block && stall_en) begin
                hash_ready = 1'b0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    chk("stall_stop_sending", 128'(stop_sending), 128'd1);
                end
                hash_ready = 1'b1;
            end else if (next && final_block) begin
                repeat (6) @(negedge clk);
                d = {16{32'hD100_0000 + 32'(dig_issued)}};
                dq.push_back(d);
                last_digest = d;
                dig_issued++;
                digest       = d;
                digest_valid = 1'b1;
                @(negedge clk);
                digest_valid = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        new_hash_request = 1'b0;
        data_in = 32'h0; valid_in = 1'b0; last_in = 1'b0; last_bytes = 3'd0;
        hash_ready = 1'b1; digest = '0; digest_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stop_sending", 128'(stop_sending), 128'd1);
        chk("rst_cmds", {124'd0, init, next, final_block, digest_out_valid}, 128'd0);
        chk("rst_data_length", data_length, 128'd0);
        chk("rst_block_or", 128'(|block), 128'd0);
        reset = 1'b0;
        @(negedge clk);

        run_msg(1, 1, 3, 32'h6162_63FF);          // "abc"
        run_msg(2, 32, 4, msg_word(2, 0));        // exactly one full block
        stall_en = 1'b1;
        run_msg(3, 33, 4, msg_word(3, 0));        // two blocks, core stalls after the first
        stall_en = 1'b0;
        run_msg(4, 1, 0, 32'hDEAD_BEEF);          // empty message
        run_msg(5, 2, 1, msg_word(5, 0));         // partial last word

        // Reset in the middle of filling.
        new_hash_request = 1'b1;
        @(negedge clk);
        new_hash_request = 1'b0;
        for (int i = 0; i < 5; i++) send_word(msg_word(6, i), 1'b0, 4);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_stop_sending", 128'(stop_sending), 128'd1);
        chk("midrst_cmds", {124'd0, init, next, final_block, digest_out_valid}, 128'd0);
        chk("midrst_data_length", data_length, 128'd0);
        chk("midrst_block_or", 128'(|block), 128'd0);
        chk("midrst_digest_out", digest_out[127:0], 128'd0);
        reset = 1'b0;
        @(negedge clk);
        run_msg(7, 1, 3, 32'h6162_63AA);
        repeat (10) @(negedge clk);
        chk("digest_out_hold", digest_out[127:0], last_digest[127:0]);
        chk("scoreboard_blocks_left", 128'(eq.size()), 128'd0);
        chk("scoreboard_digests_left", 128'(dq.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
